// File: rtl/instr_loader.sv
// Instruction-memory writer: turns a length/data/checksum byte frame into
// little-endian 32-bit word writes while holding the core in reset.
module instr_loader #(
  parameter int unsigned DEPTH_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << DEPTH_W;

  state_t           state, state_nx;
  logic [15:0]      count;
  logic [DEPTH_W:0] idx;
  logic [DEPTH_W:0] idx_inc;
  logic [1:0]       lane;
  logic [7:0]       csum;
  logic [23:0]      word;   // lanes 0..2; lane 3 goes straight into wr_data
  logic [15:0]      len_full;
  logic             accept;

  assign accept   = byte_valid && byte_ready;
  assign len_full = {byte_data, count[7:0]};
  assign idx_inc  = idx + (DEPTH_W+1)'(1);

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    core_hold  = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LEN0;
      end
      LEN0: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        core_hold  = 1'b1;
        if (byte_valid) state_nx = LEN1;
      end
      LEN1: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        core_hold  = 1'b1;
        if (byte_valid) begin
          if (len_full == 16'd0)                state_nx = CSUM;
          else if ({1'b0, len_full} > MAX_WORDS) state_nx = ERR;
          else                                   state_nx = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        core_hold  = 1'b1;
        if (byte_valid && lane == 2'd3) state_nx = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
        if (17'(idx_inc) == {1'b0, count}) state_nx = CSUM;
        else                               state_nx = DATA;
      end
      CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        core_hold  = 1'b1;
        if (byte_valid) state_nx = (byte_data == csum) ? DONE : ERR;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = LEN0;
      end
      ERR: begin
        // keep the core parked so a partial image never executes
        error     = 1'b1;
        core_hold = 1'b1;
        if (start) state_nx = LEN0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      idx     <= '0;
      lane    <= '0;
      csum    <= '0;
      word    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            count <= '0;
            idx   <= '0;
            lane  <= '0;
            csum  <= '0;
          end
        end
        LEN0: if (accept) count[7:0]  <= byte_data;
        LEN1: if (accept) count[15:8] <= byte_data;
        DATA: begin
          if (accept) begin
            csum <= csum ^ byte_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word[7:0]   <= byte_data;
              2'd1: word[15:8]  <= byte_data;
              2'd2: word[23:16] <= byte_data;
              default: begin
                // registered here so the strobe lands one cycle after lane 3
                wr_data <= {byte_data, word};
                wr_addr <= BASE_ADDR + (32'(idx) << 2);
              end
            endcase
          end
        end
        WRITE: idx <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: frames driven byte by byte, expected writes
// queued as each word completes and popped when wr_en is seen.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, wr_en, core_hold, busy, done, error;
  logic [31:0] wr_addr, wr_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[256];
  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  logic        last_wr = 1'b0;
  logic        last_rdy = 1'b0;

  always #5 clk = ~clk;

  instr_loader #(.DEPTH_W(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: observe at negedge (scoreboard pop), return 1ns after posedge
  task automatic tick();
    wr_t e;
    @(negedge clk);
    last_rdy = byte_ready;
    if (last_wr) check("ready_after_write", {31'd0, byte_ready}, 32'd1);
    last_wr = wr_en;
    if (wr_en) begin
      wr_cnt++;
      check("ready_in_write", {31'd0, byte_ready}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_write", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    do begin
      tick();
      n++;
    end while (!last_rdy && n < 50);
    if (!last_rdy) check("accept_timeout", {31'd0, last_rdy}, 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
  endfunction

  // full frame body from LEN0: length, words[0..n-1], checksum (optionally corrupted)
  task automatic load(input int n, input bit bad, input int maxgap);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    wr_t e;
    send_byte(n[7:0], pick_gap(maxgap));
    send_byte(n[15:8], pick_gap(maxgap));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[i][8*k +: 8];
        cs = cs ^ b;
        if (k == 3) begin
          e.addr = 32'(i) * 32'd4;
          e.data = words[i];
          exp_q.push_back(e);
        end
        send_byte(b, pick_gap(maxgap));
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, pick_gap(maxgap));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, wr_addr, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_hold"}, {31'd0, core_hold}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    tick(); tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // nominal two-word frame, byte_valid held through each WRITE
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_006F;
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_hold", {31'd0, core_hold}, 32'd1);
    load(2, 1'b0, 0);
    check("nom_done", {31'd0, done}, 32'd1);
    check("nom_error", {31'd0, error}, 32'd0);
    check("nom_hold", {31'd0, core_hold}, 32'd0);
    check("nom_busy", {31'd0, busy}, 32'd0);
    check("nom_pending", 32'(exp_q.size()), 32'd0);

    // zero-length frame
    base = wr_cnt;
    pulse_start();
    load(0, 1'b0, 0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_writes", 32'(wr_cnt - base), 32'd0);

    // oversize length 257
    base = wr_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("over_error", {31'd0, error}, 32'd1);
    check("over_hold", {31'd0, core_hold}, 32'd1);
    check("over_ready", {31'd0, byte_ready}, 32'd0);
    check("over_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    check("over_writes", 32'(wr_cnt - base), 32'd0);
    pulse_start();
    check("restart_error", {31'd0, error}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    load(2, 1'b0, 0);
    check("restart_done", {31'd0, done}, 32'd1);

    // bad checksum: writes happen, load reports error
    base = wr_cnt;
    pulse_start();
    load(2, 1'b1, 0);
    check("badcs_writes", 32'(wr_cnt - base), 32'd2);
    check("badcs_error", {31'd0, error}, 32'd1);
    check("badcs_done", {31'd0, done}, 32'd0);
    check("badcs_hold", {31'd0, core_hold}, 32'd1);

    // same random frame back-to-back and with random valid gaps
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    pulse_start();
    load(6, 1'b0, 0);
    check("burst_done", {31'd0, done}, 32'd1);
    pulse_start();
    load(6, 1'b0, 3);
    check("gaps_done", {31'd0, done}, 32'd1);
    check("gaps_pending", 32'(exp_q.size()), 32'd0);

    // full-depth frame: last write lands at 0x3FC
    for (int i = 0; i < 256; i++) words[i] = $urandom;
    base = wr_cnt;
    pulse_start();
    load(256, 1'b0, 0);
    check("full_done", {31'd0, done}, 32'd1);
    check("full_writes", 32'(wr_cnt - base), 32'd256);

    // reset after two data bytes, then reload cleanly
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_006F;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    base = wr_cnt;
    pulse_start();
    load(2, 1'b0, 1);
    check("midrst_done", {31'd0, done}, 32'd1);
    check("midrst_writes", 32'(wr_cnt - base), 32'd2);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
